// File: rtl/mesi_pkg.sv
// mesi_pkg: shared types for the MESI coherence unit.
//   mesi_t      - MESI line state encoding (M=00, E=01, S=10, I=11)
//   ccu_state_t - coherence unit FSM states
//   core_id_t   - identifies one of the two L1 controllers
//   core_onehot - turns a core id into a one-hot per-core strobe
package mesi_pkg;

    typedef enum logic [1:0] {
        M = 2'b00,
        E = 2'b01,
        S = 2'b10,
        I = 2'b11
    } mesi_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SNOOP    = 2'b01,
        MEM_WAIT = 2'b10,
        RESPOND  = 2'b11
    } ccu_state_t;

    typedef logic core_id_t;

    function automatic logic [1:0] core_onehot(input core_id_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter.
//   clk, rst  - clock, asynchronous active-high reset
//   req[1:0]  - requesting cores
//   advance   - a grant is being consumed this cycle; rotate priority
//   grant[1:0]- one-hot grant (combinational), zero when nothing requests
// On a tie the core that was not served last wins; after reset core 0 wins.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // Core favoured on the next tie.
    logic prio;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = prio ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            // The winner just served becomes the loser of the next tie.
            prio <= ~grant[1];
        end
    end

endmodule

// File: rtl/mesi_ccu.sv
// mesi_ccu: coherence unit serving two L1 controllers, one transaction at a time.
// A granted miss/upgrade snoops the peer L1; on a peer hit the peer's word is
// returned, otherwise (peer miss or snoop timeout) the word is read from memory.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   core_req/rd/wr/addr      - level requests from core 0/1, held until core_ready
//   core_ready               - one-cycle completion pulse to the requester
//   resp_data, resp_state    - returned word and requester's new MESI state
//   bs_req, snoop_addr       - snoop request to the peer core and its address
//   snoop_upd_state          - peer's new MESI state, applied by the peer on a hit
//   snoop_done, bs_resp,
//   snoop_data               - snoop answer strobe, hit flag and word per core
//   mem_req, mem_addr        - memory read request, held until mem_ready
//   mem_ready, mem_rdata     - memory read strobe and data
module mesi_ccu
    import mesi_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SNOOP_TO = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             core_req,
    input  logic [1:0]             core_rd,
    input  logic [1:0]             core_wr,
    input  logic [1:0][ADDR_W-1:0] core_addr,
    output logic [1:0]             core_ready,
    output logic [DATA_W-1:0]      resp_data,
    output mesi_t                  resp_state,
    output logic [1:0]             bs_req,
    output logic [ADDR_W-1:0]      snoop_addr,
    output mesi_t                  snoop_upd_state,
    input  logic [1:0]             snoop_done,
    input  logic [1:0]             bs_resp,
    input  logic [1:0][DATA_W-1:0] snoop_data,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_ready,
    input  logic [DATA_W-1:0]      mem_rdata
);

    localparam int                CNT_W   = $clog2(SNOOP_TO + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SNOOP_TO);

    ccu_state_t        state;
    core_id_t          req_id;
    logic              is_wr;
    logic [CNT_W-1:0]  to_cnt;
    logic [CNT_W-1:0]  to_cnt_nxt;
    logic [1:0]        eligible;
    logic [1:0]        grant;
    core_id_t          gid;
    core_id_t          peer;

    // Saturating increment: the timeout counter must never wrap back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // A request without a rd/wr qualifier carries no operation and is not arbitrated.
    assign eligible   = core_req & (core_rd | core_wr);
    assign gid        = grant[1];
    assign peer       = ~req_id;
    assign to_cnt_nxt = sat_inc(to_cnt);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (eligible),
        .advance (state == IDLE),
        .grant   (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            req_id          <= 1'b0;
            is_wr           <= 1'b0;
            to_cnt          <= '0;
            core_ready      <= 2'b00;
            resp_data       <= '0;
            resp_state      <= I;
            bs_req          <= 2'b00;
            snoop_addr      <= '0;
            snoop_upd_state <= I;
            mem_req         <= 1'b0;
            mem_addr        <= '0;
        end else begin
            core_ready <= 2'b00;
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        req_id          <= gid;
                        // Write (ownership) wins when both qualifiers are high.
                        is_wr           <= core_wr[gid];
                        snoop_addr      <= core_addr[gid];
                        snoop_upd_state <= core_wr[gid] ? I : S;
                        bs_req          <= core_onehot(~gid);
                        to_cnt          <= '0;
                        state           <= SNOOP;
                    end
                end
                SNOOP: begin
                    to_cnt <= to_cnt_nxt;
                    // A real answer takes priority over a timeout in the same cycle.
                    if (snoop_done[peer] && bs_resp[peer]) begin
                        bs_req     <= 2'b00;
                        resp_data  <= snoop_data[peer];
                        resp_state <= is_wr ? M : S;
                        core_ready <= core_onehot(req_id);
                        state      <= RESPOND;
                    end else if (snoop_done[peer] || (to_cnt_nxt == CNT_MAX)) begin
                        bs_req   <= 2'b00;
                        mem_req  <= 1'b1;
                        mem_addr <= snoop_addr;
                        state    <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        mem_req    <= 1'b0;
                        resp_data  <= mem_rdata;
                        resp_state <= is_wr ? M : E;
                        core_ready <= core_onehot(req_id);
                        state      <= RESPOND;
                    end
                end
                RESPOND: begin
                    // core_ready is high for exactly this cycle.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mesi_ccu.sv
// tb_mesi_ccu: self-checking bench for mesi_ccu. The bench plays both L1
// controllers and memory; expected data, states and latencies come from a
// transaction-level model of the coherence rules.
module tb_mesi_ccu;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        core_req = '0;
    logic [1:0]        core_rd = '0;
    logic [1:0]        core_wr = '0;
    logic [1:0][31:0]  core_addr = '0;
    logic [1:0]        core_ready;
    logic [31:0]       resp_data;
    logic [1:0]        resp_state;
    logic [1:0]        bs_req;
    logic [31:0]       snoop_addr;
    logic [1:0]        snoop_upd_state;
    logic [1:0]        snoop_done = '0;
    logic [1:0]        bs_resp = '0;
    logic [1:0][31:0]  snoop_data = '0;
    logic              mem_req;
    logic [31:0]       mem_addr;
    logic              mem_ready = 1'b0;
    logic [31:0]       mem_rdata = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mesi_ccu #(.ADDR_W(32), .DATA_W(32), .SNOOP_TO(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .core_req        (core_req),
        .core_rd         (core_rd),
        .core_wr         (core_wr),
        .core_addr       (core_addr),
        .core_ready      (core_ready),
        .resp_data       (resp_data),
        .resp_state      (resp_state),
        .bs_req          (bs_req),
        .snoop_addr      (snoop_addr),
        .snoop_upd_state (snoop_upd_state),
        .snoop_done      (snoop_done),
        .bs_resp         (bs_resp),
        .snoop_data      (snoop_data),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; strobes last one cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        snoop_done = '0;
        bs_resp    = '0;
        mem_ready  = 1'b0;
    endtask

    // One transaction from core c. snoop_lat: SNOOP cycle (1-based) in which the
    // peer answers; values above 16 mean the peer never answers.
    task automatic txn(input string tag, input int c, input bit wr, input logic [31:0] a,
                       input int snoop_lat, input bit hit, input logic [31:0] sdata,
                       input int mem_lat, input logic [31:0] mdata,
                       input bit noise, input bit drop_early);
        int p = 1 - c;
        int bs_n = 0;
        int mem_n = 0;
        int cyc = 0;
        bit got = 0;
        bit answered = (snoop_lat >= 1) && (snoop_lat <= 16);
        bit eff_hit = answered && hit;
        int exp_bs = answered ? snoop_lat : 16;
        int exp_mem = eff_hit ? 0 : mem_lat;
        logic [31:0] exp_data = eff_hit ? sdata : mdata;
        logic [1:0] exp_state = wr ? 2'b00 : (eff_hit ? 2'b10 : 2'b01);
        logic [1:0] exp_upd = wr ? 2'b11 : 2'b10;

        tick();
        core_req[c]  = 1'b1;
        core_rd[c]   = ~wr;
        core_wr[c]   = wr;
        core_addr[c] = a;
        for (int k = 1; k <= 200; k++) begin
            tick();
            cyc = k;
            if (drop_early && k == 2) core_req[c] = 1'b0;
            if (core_ready != 2'b00) begin
                chk({tag, ".ready"}, {30'd0, core_ready}, (c == 1) ? 32'd2 : 32'd1);
                chk({tag, ".data"}, resp_data, exp_data);
                chk({tag, ".state"}, {30'd0, resp_state}, {30'd0, exp_state});
                chk({tag, ".latency"}, cyc, exp_bs + exp_mem + 1);
                chk({tag, ".snoop_cycles"}, bs_n, exp_bs);
                chk({tag, ".mem_cycles"}, mem_n, exp_mem);
                got = 1;
                break;
            end
            if (bs_req != 2'b00) begin
                bs_n++;
                if (bs_n == 1) begin
                    chk({tag, ".bs_req"}, {30'd0, bs_req}, (p == 1) ? 32'd2 : 32'd1);
                    chk({tag, ".snoop_addr"}, snoop_addr, a);
                    chk({tag, ".upd_state"}, {30'd0, snoop_upd_state}, {30'd0, exp_upd});
                    if (noise) begin
                        snoop_done[c] = 1'b1;
                        bs_resp[c]    = 1'b1;
                        snoop_data[c] = ~sdata;
                    end
                end
                if (bs_n == snoop_lat) begin
                    snoop_done[p] = 1'b1;
                    bs_resp[p]    = hit;
                    snoop_data[p] = sdata;
                end
            end
            if (mem_req) begin
                mem_n++;
                if (mem_n == 1) chk({tag, ".mem_addr"}, mem_addr, a);
                if (mem_n == mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = mdata;
                end
            end
        end
        if (!got) chk({tag, ".timeout"}, 32'd0, 32'd1);
        core_req[c] = 1'b0;
        core_rd[c]  = 1'b0;
        core_wr[c]  = 1'b0;
    endtask

    initial begin
        bit got;
        int exp_c;
        int ready_cnt;
        int idle_bad;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst.core_ready", {30'd0, core_ready}, 32'd0);
        chk("rst.resp_data", resp_data, 32'd0);
        chk("rst.resp_state", {30'd0, resp_state}, 32'd3);
        chk("rst.bs_req", {30'd0, bs_req}, 32'd0);
        chk("rst.snoop_upd", {30'd0, snoop_upd_state}, 32'd3);
        chk("rst.mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.snoop_addr", snoop_addr, 32'd0);
        rst = 1'b0;

        // Directed transactions
        txn("t1_rd_hit", 0, 1'b0, 32'h0000_1040, 1, 1'b1, 32'hDEAD_BEEF, 1, 32'h0, 1'b0, 1'b0);
        txn("t2_rd_miss", 1, 1'b0, 32'h0000_2000, 2, 1'b0, 32'h0, 5, 32'h1234_5678, 1'b0, 1'b0);
        txn("t3_wr_hit", 0, 1'b1, 32'h0000_3000, 3, 1'b1, 32'hCAFE_0001, 1, 32'h0, 1'b0, 1'b0);
        txn("t3_wr_miss", 0, 1'b1, 32'h0000_3000, 1, 1'b0, 32'h0, 3, 32'hCAFE_0002, 1'b0, 1'b0);
        txn("t5_timeout", 1, 1'b0, 32'h0000_5000, 99, 1'b1, 32'h0, 2, 32'h5555_AAAA, 1'b0, 1'b0);
        txn("t_noise_drop", 1, 1'b0, 32'h0000_6000, 4, 1'b1, 32'h6666_0000, 1, 32'h0, 1'b1, 1'b1);
        txn("t_edge16", 0, 1'b0, 32'h0000_7000, 16, 1'b1, 32'h7777_0016, 1, 32'h0, 1'b0, 1'b0);

        // Reset asserted in MEM_WAIT
        tick();
        core_req[1] = 1'b1; core_wr[1] = 1'b1; core_addr[1] = 32'h0000_8000;
        got = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (mem_req) begin got = 1; break; end
            if (bs_req != 2'b00) begin snoop_done[0] = 1'b1; bs_resp[0] = 1'b0; end
        end
        chk("t6.reach_mem_wait", {31'd0, got}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6.async_mem_req", {31'd0, mem_req}, 32'd0);
        chk("t6.async_mem_addr", mem_addr, 32'd0);
        chk("t6.async_resp_state", {30'd0, resp_state}, 32'd3);
        chk("t6.async_upd", {30'd0, snoop_upd_state}, 32'd3);
        core_req = '0; core_wr = '0; core_rd = '0;
        tick();
        rst = 1'b0;
        // Stray mem_ready and snoop_done while idle must be ignored.
        mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        snoop_done = 2'b11; bs_resp = 2'b11;
        idle_bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (core_ready != 2'b00 || mem_req || bs_req != 2'b00) idle_bad++;
        end
        chk("t6.no_response", idle_bad, 32'd0);

        // Simultaneous requests alternate, core 0 first after reset
        core_req = 2'b11; core_rd = 2'b11; core_wr = 2'b00;
        core_addr[0] = 32'h0000_A000; core_addr[1] = 32'h0000_B000;
        exp_c = 0;
        for (int n = 0; n < 4; n++) begin
            got = 0;
            ready_cnt = 0;
            for (int k = 0; k < 50; k++) begin
                tick();
                if (core_ready != 2'b00) begin
                    chk("t4.grant", {30'd0, core_ready}, (exp_c == 1) ? 32'd2 : 32'd1);
                    chk("t4.data", resp_data, 32'hA000_0000 | n);
                    got = 1;
                    break;
                end
                if (bs_req != 2'b00) begin
                    snoop_done = bs_req;
                    bs_resp    = bs_req;
                    snoop_data = {32'hA000_0000 | n, 32'hA000_0000 | n};
                end
            end
            if (n == 3) core_req = 2'b00;
            tick();
            if (core_ready != 2'b00) ready_cnt++;
            chk("t4.single_ready", ready_cnt, 32'd0);
            if (!got) chk("t4.timeout", 32'd0, 32'd1);
            exp_c = 1 - exp_c;
        end
        core_rd = 2'b00;

        // Randomized transactions against the model
        for (int n = 0; n < 24; n++) begin
            txn($sformatf("rnd%0d", n), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom, int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)), $urandom,
                int'($urandom_range(1, 6)), $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
